cache_ctrl: RTL and testbench
=============================

Name: cache_ctrl

Overview:
- Sequencing controller for the 4-way set-associative cache.
- Accepts CPU read/write requests and drives index, tag and per-way write enables into four tag-memory instances (one per way).
- Evaluates the four per-way hit lines, picks a refill victim with a per-set tree pseudo-LRU, and runs the refill/write-through handshake to next-level memory.
- Sits between the CPU port and the tag/data arrays; the data arrays take their way-select and write strobe from this block.

Parameters:
- tagSize, 8, tag width in bits.
- indexWidth, 6, set index width in bits.
- NoOfSets, 64, number of sets; must equal 2**indexWidth.

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- cpuReq  input  1  request valid; sampled only in IDLE.
- cpuWe  input  1  1 = write, 0 = read; captured with cpuReq.
- cpuAddr  input  tagSize+indexWidth  {tag, index}; captured with cpuReq.
- cpuReady  output  1  high only in IDLE.
- cpuDone  output  1  one-cycle pulse when the access completes.
- cpuHit  output  1  valid with cpuDone; 1 = completed as a hit.
- tagOut  output  tagSize  latched tag to all tag memories.
- indexOut  output  indexWidth  latched index to all tag memories.
- tagWEn  output  4  one-hot tag write enable, one bit per way.
- wayHit  input  4  hit outputs of tag memories way0..way3.
- dataWay  output  2  way select for the data arrays.
- dataWEn  output  1  data array write strobe.
- memReq  output  1  next-level request, held until memAck.
- memWe  output  1  1 = write-through, 0 = line refill; stable while memReq is high.
- memAck  input  1  next-level completion, one-cycle pulse.

Behaviour:
- States:
  - IDLE: cpuReady=1. cpuReq=1 latches cpuWe/cpuAddr and moves to LOOKUP.
  - LOOKUP: one cycle. tagWEn=0, so the tag memories register the stored tag and valid bit at indexOut. Always moves to COMPARE.
  - COMPARE: samples wayHit.
    - Hit way = lowest-numbered set bit; multiple hits resolve to the lowest way.
    - Read hit: cpuDone=1, cpuHit=1, dataWay=hit way, update PLRU, go to IDLE. Read-hit latency is 2 cycles after acceptance.
    - Write hit: dataWEn=1, dataWay=hit way, update PLRU, go to MEMWR.
    - Read miss: latch victim into dataWay, go to REFILL.
    - Write miss: no allocate, go to MEMWR.
  - REFILL: memReq=1, memWe=0 until memAck, then go to UPDATE.
  - UPDATE: one cycle.
    - tagWEn[victim]=1, dataWEn=1, dataWay=victim.
    - Update PLRU toward the victim.
    - cpuDone=1, cpuHit=0, go to IDLE.
  - MEMWR: memReq=1, memWe=1 until memAck. Then cpuDone=1, cpuHit = 1 if the write hit in COMPARE, else 0. Go to IDLE.
- memReq rises the cycle after entry to REFILL/MEMWR and falls the cycle after memAck. memAck outside REFILL/MEMWR is ignored. memAck arriving in the first cycle of memReq is legal.
- cpuReq outside IDLE is ignored; the requester holds it until it sees cpuReady.
- PLRU: 3 bits per set, stored as a NoOfSets x 3 register array.
  - b0=0 means ways 0/1 are LRU. b1=0 means way0 is LRU. b2=0 means way2 is LRU.
  - Victim: b0 ? (b2 ? 3 : 2) : (b1 ? 1 : 0).
  - Access to way0 sets b0=1, b1=1. Way1: b0=1, b1=0. Way2: b0=0, b2=1. Way3: b0=0, b2=0.
  - Only the accessed set's bits change.
- Reset (reset=0 at a clock edge), including mid-refill:
  - State goes to IDLE; all PLRU bits clear.
  - cpuDone, cpuHit, memReq, memWe, tagWEn, dataWEn, dataWay, tagOut and indexOut all return to 0. cpuReady becomes 1 the first cycle after reset is released.
  - An outstanding memAck after reset is ignored.
- All outputs are registered or decoded from state only; there is no combinational path from cpuReq to any output.

Optional Feature:
- Macro: CACHE_CTRL_PERF_EN.
- When defined:
  - Extra outputs hitCnt[15:0] and missCnt[15:0].
  - Each increments by 1 on the cpuDone cycle according to cpuHit.
  - Both saturate at 16'hFFFF and clear on reset.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Cold read, addr {tag=8'h3A, idx=6'd5}, wayHit=0: memReq for 1 cycle, memAck -> tagWEn=4'b0001, then cpuDone=1 with cpuHit=0; PLRU[5]=3'b011.
- Repeat the same read with wayHit=4'b0001 in COMPARE -> cpuDone=1, cpuHit=1, exactly 2 cycles after acceptance; memReq stays 0.
- Four read misses to set 5 from reset -> victims in order 0, 2, 1, 3. A fifth miss -> victim 0.
- Write hit with wayHit=4'b0100 -> dataWEn with dataWay=2 in COMPARE, then memReq and memWe=1. After memAck -> cpuDone=1, cpuHit=1; tagWEn stays 0.
- Write miss -> memWe=1 write-through, cpuDone=1 with cpuHit=0; no tagWEn pulse; PLRU unchanged.
- reset=0 for one clock during REFILL with memReq=1 -> memReq=0 next cycle, state IDLE, cpuReady=1; a late memAck produces no cpuDone. Under CACHE_CTRL_PERF_EN, both counters read 0.

Source files
------------

// File: rtl/cache_ctrl.sv
// cache_ctrl: sequencing controller for a 4-way set-associative cache.
// Accepts CPU requests, drives the tag memories, resolves hits, picks a
// refill victim through a per-set tree pseudo-LRU and runs the refill and
// write-through handshake with next-level memory.
//
// Every output except cpuReady is a flop whose value is decided while the
// FSM sits in a state and becomes visible in the following cycle.
// cpuReady is decoded directly from the state register.
//
// Optional feature: define CACHE_CTRL_PERF_EN to add saturating 16-bit
// hit/miss counters (hitCnt, missCnt).
module cache_ctrl #(
    parameter int tagSize    = 8,
    parameter int indexWidth = 6,
    parameter int NoOfSets   = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cpuReq,
    input  logic                          cpuWe,
    input  logic [tagSize+indexWidth-1:0] cpuAddr,
    output logic                          cpuReady,
    output logic                          cpuDone,
    output logic                          cpuHit,
    output logic [tagSize-1:0]            tagOut,
    output logic [indexWidth-1:0]         indexOut,
    output logic [3:0]                    tagWEn,
    input  logic [3:0]                    wayHit,
    output logic [1:0]                    dataWay,
    output logic                          dataWEn,
    output logic                          memReq,
    output logic                          memWe,
    input  logic                          memAck
`ifdef CACHE_CTRL_PERF_EN
    ,
    output logic [15:0]                   hitCnt,
    output logic [15:0]                   missCnt
`endif
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOOKUP  = 3'd1,
        COMPARE = 3'd2,
        REFILL  = 3'd3,
        UPDATE  = 3'd4,
        MEMWR   = 3'd5
    } state_t;

    // Victim from tree bits {b2,b1,b0}: b0 picks the pair, b1/b2 the way in it.
    function automatic logic [1:0] plru_victim(input logic [2:0] bits);
        logic [1:0] way;
        if (bits[0]) begin
            way = bits[2] ? 2'd3 : 2'd2;
        end else begin
            way = bits[1] ? 2'd1 : 2'd0;
        end
        return way;
    endfunction

    // Point the tree away from the way just used.
    function automatic logic [2:0] plru_touch(input logic [2:0] bits, input logic [1:0] way);
        logic [2:0] nxt;
        case (way)
            2'd0:    nxt = {bits[2], 1'b1, 1'b1};
            2'd1:    nxt = {bits[2], 1'b0, 1'b1};
            2'd2:    nxt = {1'b1, bits[1], 1'b0};
            2'd3:    nxt = {1'b0, bits[1], 1'b0};
            default: nxt = bits;
        endcase
        return nxt;
    endfunction

    // Multiple hits resolve to the lowest-numbered way.
    function automatic logic [1:0] lowest_way(input logic [3:0] hits);
        logic [1:0] way;
        if (hits[0]) begin
            way = 2'd0;
        end else if (hits[1]) begin
            way = 2'd1;
        end else if (hits[2]) begin
            way = 2'd2;
        end else begin
            way = 2'd3;
        end
        return way;
    endfunction

    state_t                  state_q, state_d;
    logic                    we_q, we_d;
    logic [tagSize-1:0]      tag_q, tag_d;
    logic [indexWidth-1:0]   index_q, index_d;
    logic                    cpu_done_q, cpu_done_d;
    logic                    cpu_hit_q, cpu_hit_d;
    logic [3:0]              tag_wen_q, tag_wen_d;
    logic [1:0]              data_way_q, data_way_d;
    logic                    data_wen_q, data_wen_d;
    logic                    mem_req_q, mem_req_d;
    logic                    mem_we_q, mem_we_d;
    logic                    wr_hit_q, wr_hit_d;
    logic [2:0]              plru_q [NoOfSets];
    logic                    plru_wen_s;
    logic [2:0]              plru_wval_s;
    logic [2:0]              cur_plru_s;
    logic                    ack_s;

    assign cur_plru_s = plru_q[index_q];
    // memAck only counts once our request is actually on the bus.
    assign ack_s      = mem_req_q & memAck;

    // Next-state, next-output and PLRU-update decode for the sequencing FSM.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        tag_d       = tag_q;
        index_d     = index_q;
        cpu_done_d  = 1'b0;
        cpu_hit_d   = 1'b0;
        tag_wen_d   = 4'b0000;
        data_way_d  = data_way_q;
        data_wen_d  = 1'b0;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        wr_hit_d    = wr_hit_q;
        plru_wen_s  = 1'b0;
        plru_wval_s = cur_plru_s;
        case (state_q)
            IDLE: begin
                if (cpuReq) begin
                    we_d    = cpuWe;
                    tag_d   = cpuAddr[tagSize+indexWidth-1:indexWidth];
                    index_d = cpuAddr[indexWidth-1:0];
                    state_d = LOOKUP;
                end else begin
                    state_d = IDLE;
                end
            end
            LOOKUP: begin
                state_d = COMPARE;
            end
            COMPARE: begin
                if (|wayHit) begin
                    data_way_d  = lowest_way(wayHit);
                    plru_wen_s  = 1'b1;
                    plru_wval_s = plru_touch(cur_plru_s, lowest_way(wayHit));
                    wr_hit_d    = 1'b1;
                    if (we_q) begin
                        data_wen_d = 1'b1;
                        state_d    = MEMWR;
                    end else begin
                        cpu_done_d = 1'b1;
                        cpu_hit_d  = 1'b1;
                        state_d    = IDLE;
                    end
                end else begin
                    wr_hit_d = 1'b0;
                    if (we_q) begin
                        state_d = MEMWR;
                    end else begin
                        data_way_d = plru_victim(cur_plru_s);
                        state_d    = REFILL;
                    end
                end
            end
            REFILL: begin
                if (ack_s) begin
                    state_d = UPDATE;
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            UPDATE: begin
                tag_wen_d   = 4'b0001 << data_way_q;
                data_wen_d  = 1'b1;
                plru_wen_s  = 1'b1;
                plru_wval_s = plru_touch(cur_plru_s, data_way_q);
                cpu_done_d  = 1'b1;
                cpu_hit_d   = 1'b0;
                state_d     = IDLE;
            end
            MEMWR: begin
                if (ack_s) begin
                    cpu_done_d = 1'b1;
                    cpu_hit_d  = wr_hit_q;
                    state_d    = IDLE;
                end else begin
                    mem_req_d = 1'b1;
                    mem_we_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, output and PLRU registers; reset also aborts any refill in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            tag_q      <= '0;
            index_q    <= '0;
            cpu_done_q <= 1'b0;
            cpu_hit_q  <= 1'b0;
            tag_wen_q  <= 4'b0000;
            data_way_q <= 2'd0;
            data_wen_q <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            wr_hit_q   <= 1'b0;
            for (int i = 0; i < NoOfSets; i++) begin
                plru_q[i] <= 3'b000;
            end
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            tag_q      <= tag_d;
            index_q    <= index_d;
            cpu_done_q <= cpu_done_d;
            cpu_hit_q  <= cpu_hit_d;
            tag_wen_q  <= tag_wen_d;
            data_way_q <= data_way_d;
            data_wen_q <= data_wen_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            wr_hit_q   <= wr_hit_d;
            if (plru_wen_s) begin
                plru_q[index_q] <= plru_wval_s;
            end
        end
    end

    assign cpuReady = (state_q == IDLE);
    assign cpuDone  = cpu_done_q;
    assign cpuHit   = cpu_hit_q;
    assign tagOut   = tag_q;
    assign indexOut = index_q;
    assign tagWEn   = tag_wen_q;
    assign dataWay  = data_way_q;
    assign dataWEn  = data_wen_q;
    assign memReq   = mem_req_q;
    assign memWe    = mem_we_q;

`ifdef CACHE_CTRL_PERF_EN
    logic [15:0] hit_cnt_q, hit_cnt_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;

    // Saturating hit/miss counters, stepped on the cpuDone cycle.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (cpu_done_q) begin
            if (cpu_hit_q) begin
                hit_cnt_d = (hit_cnt_q == 16'hFFFF) ? hit_cnt_q : hit_cnt_q + 16'd1;
            end else begin
                miss_cnt_d = (miss_cnt_q == 16'hFFFF) ? miss_cnt_q : miss_cnt_q + 16'd1;
            end
        end else begin
            hit_cnt_d  = hit_cnt_q;
            miss_cnt_d = miss_cnt_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hit_cnt_q  <= 16'd0;
            miss_cnt_q <= 16'd0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hitCnt  = hit_cnt_q;
    assign missCnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: scoreboard bench for cache_ctrl. Each request pushes its
// expected completion; a negedge monitor accumulates tag/data strobes and
// memory handshake activity and compares them when cpuDone appears.
// Define CACHE_CTRL_PERF_EN to also check the hit/miss counters.
module tb_cache_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpuReq;
    logic        cpuWe;
    logic [13:0] cpuAddr;
    logic        cpuReady;
    logic        cpuDone;
    logic        cpuHit;
    logic [7:0]  tagOut;
    logic [5:0]  indexOut;
    logic [3:0]  tagWEn;
    logic [3:0]  wayHit;
    logic [1:0]  dataWay;
    logic        dataWEn;
    logic        memReq;
    logic        memWe;
    logic        memAck;
`ifdef CACHE_CTRL_PERF_EN
    logic [15:0] hitCnt;
    logic [15:0] missCnt;
`endif

    cache_ctrl #(.tagSize(8), .indexWidth(6), .NoOfSets(64)) dut (
        .clk(clk), .reset(reset), .cpuReq(cpuReq), .cpuWe(cpuWe), .cpuAddr(cpuAddr),
        .cpuReady(cpuReady), .cpuDone(cpuDone), .cpuHit(cpuHit), .tagOut(tagOut),
        .indexOut(indexOut), .tagWEn(tagWEn), .wayHit(wayHit), .dataWay(dataWay),
        .dataWEn(dataWEn), .memReq(memReq), .memWe(memWe), .memAck(memAck)
`ifdef CACHE_CTRL_PERF_EN
        , .hitCnt(hitCnt), .missCnt(missCnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       hit;
        logic [1:0] way;
        logic       chk_way;
        logic [3:0] tagwen;
        int         dwen_cnt;
        logic [1:0] dwen_way;
        int         mem_cycles;
        logic       mem_we;
        logic       chk_lat;
    } exp_t;

    exp_t       sb_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         mon_hits = 0;
    int         mon_misses = 0;
    logic [2:0] model_plru [64];

    // monitor accumulators for the transaction in flight
    logic [3:0] acc_tagwen = 4'b0000;
    int         acc_dwen = 0;
    logic [1:0] acc_dwen_way = 2'd0;
    int         acc_mreq = 0;
    int         acc_mwe = 0;
    int         lat = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] m_victim(input logic [2:0] b);
        if (b[0]) return b[2] ? 2'd3 : 2'd2;
        else      return b[1] ? 2'd1 : 2'd0;
    endfunction

    function automatic logic [2:0] m_touch(input logic [2:0] b, input logic [1:0] w);
        logic [2:0] r;
        r = b;
        if (w == 2'd0)      begin r[0] = 1'b1; r[1] = 1'b1; end
        else if (w == 2'd1) begin r[0] = 1'b1; r[1] = 1'b0; end
        else if (w == 2'd2) begin r[0] = 1'b0; r[2] = 1'b1; end
        else                begin r[0] = 1'b0; r[2] = 1'b0; end
        return r;
    endfunction

    // Monitor: accumulate strobes, compare on cpuDone, restart on acceptance.
    always @(negedge clk) begin
        exp_t e;
        lat = lat + 1;
        acc_tagwen = acc_tagwen | tagWEn;
        if (dataWEn) begin
            acc_dwen = acc_dwen + 1;
            acc_dwen_way = dataWay;
        end
        if (memReq) begin
            acc_mreq = acc_mreq + 1;
            if (memWe) acc_mwe = acc_mwe + 1;
        end
        if (cpuDone) begin
            if (sb_q.size() == 0) begin
                check_val("spurious_done", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_val("cpu_hit", cpuHit, e.hit);
                if (e.chk_way) check_val("data_way", dataWay, e.way);
                check_val("tag_wen", acc_tagwen, e.tagwen);
                check_val("data_wen_cnt", acc_dwen, e.dwen_cnt);
                if (e.dwen_cnt > 0) check_val("data_wen_way", acc_dwen_way, e.dwen_way);
                check_val("mem_req_cycles", acc_mreq, e.mem_cycles);
                check_val("mem_we_cycles", acc_mwe, e.mem_we ? e.mem_cycles : 0);
                // request seen at negedge 0, accepted at the next edge; done
                // registered two edges later is seen at negedge 3
                if (e.chk_lat) check_val("read_hit_latency", lat, 32'd3);
                if (cpuHit) mon_hits = mon_hits + 1;
                else        mon_misses = mon_misses + 1;
            end
        end
        if (cpuReq && cpuReady) begin
            lat = 0;
            acc_tagwen = 4'b0000;
            acc_dwen = 0;
            acc_mreq = 0;
            acc_mwe = 0;
        end
    end

    task automatic wait_ready();
        int k;
        k = 0;
        while (!cpuReady && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (!cpuReady) check_val("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_memreq(output logic ok);
        int k;
        k = 0;
        while (!memReq && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        ok = memReq;
        if (!ok) check_val("memreq_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_access(input logic we, input logic [7:0] tg, input logic [5:0] idx,
                             input logic [3:0] wh, input int ackdly);
        exp_t       e;
        logic [1:0] hw;
        logic [1:0] v;
        logic       ok;
        wait_ready();
        hw = 2'd0;
        for (int i = 3; i >= 0; i--) if (wh[i]) hw = 2'(i);
        e.hit = |wh; e.way = 2'd0; e.chk_way = 1'b0; e.tagwen = 4'b0000;
        e.dwen_cnt = 0; e.dwen_way = 2'd0; e.mem_cycles = 0; e.mem_we = we; e.chk_lat = 1'b0;
        if (|wh) begin
            e.way = hw; e.chk_way = 1'b1;
            model_plru[idx] = m_touch(model_plru[idx], hw);
            if (we) begin
                e.dwen_cnt = 1; e.dwen_way = hw; e.mem_cycles = ackdly + 1;
            end else begin
                e.chk_lat = 1'b1;
            end
        end else if (!we) begin
            v = m_victim(model_plru[idx]);
            e.way = v; e.chk_way = 1'b1; e.tagwen = 4'b0001 << v;
            e.dwen_cnt = 1; e.dwen_way = v; e.mem_cycles = ackdly + 1;
            model_plru[idx] = m_touch(model_plru[idx], v);
        end else begin
            e.mem_cycles = ackdly + 1;
        end
        sb_q.push_back(e);
        cpuReq = 1'b1; cpuWe = we; cpuAddr = {tg, idx};
        @(posedge clk); #1;
        cpuReq = 1'b0;
        check_val("tag_out", tagOut, tg);
        check_val("index_out", indexOut, idx);
        wayHit = wh;
        if (e.mem_cycles > 0) begin
            wait_memreq(ok);
            if (ok) begin
                repeat (ackdly) begin @(posedge clk); #1; end
                memAck = 1'b1;
                @(posedge clk); #1;
                memAck = 1'b0;
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic ok;
        for (int i = 0; i < 64; i++) model_plru[i] = 3'b000;
        reset = 1'b0; cpuReq = 1'b0; cpuWe = 1'b0; cpuAddr = 14'd0;
        wayHit = 4'b0000; memAck = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_cpu_done", cpuDone, 1'b0);
        check_val("rst_mem_req", memReq, 1'b0);
        check_val("rst_tag_wen", tagWEn, 4'b0000);
        check_val("rst_data_way", dataWay, 2'd0);
        check_val("rst_tag_out", tagOut, 8'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        check_val("rst_cpu_ready", cpuReady, 1'b1);

        // cold read miss, then the same read as a hit on way0
        do_access(1'b0, 8'h3A, 6'd5, 4'b0000, 0);
        do_access(1'b0, 8'h3A, 6'd5, 4'b0001, 0);
        // further misses to set 5: victims 2, 1, 3, then 0 again
        do_access(1'b0, 8'h11, 6'd5, 4'b0000, 1);
        do_access(1'b0, 8'h22, 6'd5, 4'b0000, 2);
        do_access(1'b0, 8'h33, 6'd5, 4'b0000, 0);
        do_access(1'b0, 8'h44, 6'd5, 4'b0000, 3);
        // write hit on way2, write miss, multi-hit read, hit on way3
        do_access(1'b1, 8'h3A, 6'd5, 4'b0100, 1);
        do_access(1'b1, 8'h77, 6'd9, 4'b0000, 0);
        do_access(1'b0, 8'h12, 6'd12, 4'b1010, 0);
        do_access(1'b0, 8'h3A, 6'd5, 4'b1000, 0);
        do_access(1'b0, 8'h99, 6'd9, 4'b0000, 0);
        for (int i = 0; i < 12; i++) begin
            do_access(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                      6'($urandom_range(0, 3)),
                      ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15)),
                      int'($urandom_range(0, 3)));
        end
        wait_ready();
        repeat (3) @(posedge clk);
        #1;
        check_val("sb_drained", sb_q.size(), 32'd0);
`ifdef CACHE_CTRL_PERF_EN
        check_val("hit_cnt", hitCnt, mon_hits);
        check_val("miss_cnt", missCnt, mon_misses);
`endif

        // reset in the middle of a refill
        cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = {8'h55, 6'd7};
        @(posedge clk); #1;
        cpuReq = 1'b0; wayHit = 4'b0000;
        wait_memreq(ok);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        check_val("midrst_mem_req", memReq, 1'b0);
        check_val("midrst_cpu_ready", cpuReady, 1'b1);
        check_val("midrst_tag_wen", tagWEn, 4'b0000);
`ifdef CACHE_CTRL_PERF_EN
        check_val("midrst_hit_cnt", hitCnt, 16'd0);
        check_val("midrst_miss_cnt", missCnt, 16'd0);
`endif
        memAck = 1'b1;
        @(posedge clk); #1;
        memAck = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_val("late_ack_no_done", cpuDone, 1'b0);
            check_val("late_ack_no_memreq", memReq, 1'b0);
            @(posedge clk); #1;
        end
        // PLRU cleared by reset: next miss to set 5 evicts way0 again
        for (int i = 0; i < 64; i++) model_plru[i] = 3'b000;
        do_access(1'b0, 8'h5A, 6'd5, 4'b0000, 0);
        wait_ready();
        repeat (3) @(posedge clk);
        #1;
        check_val("final_sb_drained", sb_q.size(), 32'd0);
`ifdef CACHE_CTRL_PERF_EN
        check_val("post_rst_hit_cnt", hitCnt, 16'd0);
        check_val("post_rst_miss_cnt", missCnt, 16'd1);
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
